// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared definitions for the DE1-SoC HEX display driver:
//               control-byte field positions, segment constants, the
//               lamp/run state encoding and the nibble-to-segment decoder.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

  // Control-byte field positions
  localparam int RAW_BIT   = 7;
  localparam int BLINK_BIT = 5;
  localparam int BLANK_BIT = 4;

  // Active-low segment patterns
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

  typedef enum logic [0:0] {
    LAMP = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Hex nibble to active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : hex_digit_decode
// Description : Combinational decode of one control byte into active-low
//               seven-segment drive. Raw mode passes an inverted pattern;
//               otherwise blank, then blink-off, then the hex nibble.
// Ports       : ctrl        in  8  control byte for one digit
//               blink_phase in  1  1 = blinking digits visible
//               seg         out 7  active-low segments (bit0 = a)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_digit_decode
  import hex_display_pkg::*;
(
  input  logic [7:0] ctrl,
  input  logic       blink_phase,
  output logic [6:0] seg
);

  always_comb begin
    seg = nibble_to_seg(ctrl[3:0]);
    if (ctrl[RAW_BIT]) begin
      // Raw pattern uses 1 = lit; the pins are active-low
      seg = ~ctrl[6:0];
    end else if (ctrl[BLANK_BIT]) begin
      seg = SEG_OFF;
    end else if (ctrl[BLINK_BIT] && !blink_phase) begin
      seg = SEG_OFF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_driver
// Description : Drives HEX0-HEX3 from the 32-bit HEX PIO word. Runs a lamp
//               test (all segments lit) after every reset, then decodes each
//               byte per digit with blank/blink/raw control.
//               Pipeline: data_in register -> decode -> output register.
// Ports       : clk              in  1   clock
//               reset_n          in  1   asynchronous active-low reset
//               data_in          in  32  PIO word, byte k controls HEXk
//               hex0..hex3       out 7   active-low segments (bit0 = a)
//               blink_phase      out 1   1 = blinking digits visible
//               lamp_test_active out 1   high during the lamp test
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES = 12_500_000,
  parameter int LAMP_TEST_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        blink_phase,
  output logic        lamp_test_active
);

  localparam int LAMP_W  = (LAMP_TEST_CYCLES  > 1) ? $clog2(LAMP_TEST_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [LAMP_W-1:0]  LAMP_LAST  = LAMP_W'(LAMP_TEST_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

  state_t             state;
  logic [LAMP_W-1:0]  lamp_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [31:0]        data_q;
  logic [6:0]         seg_dec [4];

  for (genvar k = 0; k < 4; k++) begin : g_digit
    hex_digit_decode u_decode (
      .ctrl        (data_q[8*k +: 8]),
      .blink_phase (blink_phase),
      .seg         (seg_dec[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= LAMP;
      lamp_cnt         <= '0;
      blink_cnt        <= '0;
      blink_phase      <= 1'b1;
      lamp_test_active <= 1'b1;
      data_q           <= '0;
      hex0             <= SEG_OFF;
      hex1             <= SEG_OFF;
      hex2             <= SEG_OFF;
      hex3             <= SEG_OFF;
    end else begin
      // Sampled in both states so a word written during the lamp test is
      // ready for the first decoded output.
      data_q <= data_in;

      if (state == LAMP) begin
        hex0        <= SEG_ALL;
        hex1        <= SEG_ALL;
        hex2        <= SEG_ALL;
        hex3        <= SEG_ALL;
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
        if (lamp_cnt == LAMP_LAST) begin
          state            <= RUN;
          lamp_test_active <= 1'b0;
          lamp_cnt         <= '0;
        end else begin
          lamp_cnt <= lamp_cnt + 1'b1;
        end
      end else begin
        hex0 <= seg_dec[0];
        hex1 <= seg_dec[1];
        hex2 <= seg_dec[2];
        hex3 <= seg_dec[3];
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_driver
// Description : Self-checking bench for hex_display_driver with
//               LAMP_TEST_CYCLES = 8 and BLINK_HALF_CYCLES = 4.
// Ports       : (testbench, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_driver;

  localparam int LAMP  = 8;
  localparam int BLINK = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        blink_phase;
  logic        lamp_test_active;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;   // posedges since the latest reset release

  typedef struct {
    string      tag;
    logic [6:0] e0, e1, e2, e3;
  } exp_t;
  exp_t sb[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_driver #(
    .BLINK_HALF_CYCLES (BLINK),
    .LAMP_TEST_CYCLES  (LAMP)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .hex0             (hex0),
    .hex1             (hex1),
    .hex2             (hex2),
    .hex3             (hex3),
    .blink_phase      (blink_phase),
    .lamp_test_active (lamp_test_active)
  );

  always #5 clk = ~clk;

  // Expected blink_phase after posedge e (e counted from reset release):
  // RUN is entered at edge LAMP, toggles every BLINK edges afterwards.
  function automatic logic phase_at(input int e);
    if (e < LAMP) return 1'b1;
    return (((e - LAMP) / BLINK) % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    assert_count++;
    assert (obs === exp_v) else begin
      fail_count++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    check({tag, ".hex0"}, hex0, e0);
    check({tag, ".hex1"}, hex1, e1);
    check({tag, ".hex2"}, hex2, e2);
    check({tag, ".hex3"}, hex3, e3);
  endtask

  // Drive a word, queue its expected digits, and compare when the output
  // register carries it two clocks later.
  task automatic apply(input string tag, input logic [31:0] d, input logic [6:0] e0,
                       input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3);
    exp_t x;
    @(negedge clk);
    data_in = d;
    sb.push_back('{tag, e0, e1, e2, e3});
    tick();
    tick();
    x = sb.pop_front();
    check_all(x.tag, x.e0, x.e1, x.e2, x.e3);
  endtask

  task automatic lamp_phase(input string tag);
    for (int i = 1; i <= LAMP; i++) begin
      tick();
      check_all({tag, ".lamp_hex"}, 7'h00, 7'h00, 7'h00, 7'h00);
      check({tag, ".lamp_active"}, {6'd0, lamp_test_active}, {6'd0, (cyc < LAMP)});
      check({tag, ".lamp_phase"}, {6'd0, blink_phase}, 7'd1);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    data_in = 32'h0001_0203;
    #2 reset_n = 1'b0;
    #1;
    check_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("reset.phase", {6'd0, blink_phase}, 7'd1);
    check("reset.lamp", {6'd0, lamp_test_active}, 7'd1);

    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    lamp_phase("lamp1");

    // Word written during the lamp test shows on the first decoded output
    tick();
    check_all("first_run", 7'h30, 7'h24, 7'h79, 7'h40);
    check("first_run.lamp", {6'd0, lamp_test_active}, 7'd0);

    apply("digits0123", 32'h0001_0203, 7'h30, 7'h24, 7'h79, 7'h40);
    apply("blank_wins", 32'h1F0E_0D0C, 7'h46, 7'h21, 7'h06, 7'h7F);
    apply("raw_a5",     32'h0000_00A5, 7'h5A, 7'h40, 7'h40, 7'h40);
    for (int i = 0; i < 2 * BLINK; i++) begin
      tick();
      check("raw_steady", hex0, 7'h5A);
      check("raw_phase", {6'd0, blink_phase}, {6'd0, phase_at(cyc)});
    end

    // Blinking nibble 5: output follows the phase of the previous cycle
    @(negedge clk);
    data_in = 32'h0000_0025;
    tick();
    for (int i = 0; i < 3 * BLINK; i++) begin
      tick();
      check("blink_hex0", hex0, phase_at(cyc - 1) ? 7'h12 : 7'h7F);
      check("blink_phase", {6'd0, blink_phase}, {6'd0, phase_at(cyc)});
    end

    for (int n = 0; n < 16; n++) begin
      logic [31:0] w;
      w = {4'h0, 4'(n), 24'h0};
      apply($sformatf("sweep_%0h", n), w, 7'h40, 7'h40, 7'h40, seg_tab[n]);
    end

    // Mid-blink asynchronous reset
    @(negedge clk);
    data_in = 32'h0000_0025;
    repeat (BLINK + 1) tick();
    #3 reset_n = 1'b0;
    #1;
    check_all("async_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("async_rst.phase", {6'd0, blink_phase}, 7'd1);
    check("async_rst.lamp", {6'd0, lamp_test_active}, 7'd1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    lamp_phase("lamp2");
    tick();
    check_all("rerun", 7'h12, 7'h40, 7'h40, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_driver.md
# hex_display_driver

Consumes the 32-bit `out_port` word produced by the HEX PIO register and drives four active-low seven-segment displays (HEX0–HEX3) on the DE1-SoC. Each byte of the word controls one digit, which can show a hex nibble, be blanked, blink, or take a raw segment pattern. After every reset the block runs a lamp test with all segments lit, then enters normal display mode. It sits between the Platform Designer PIO output and the top-level HEX pins.

## Interface
Parameters:
- `BLINK_HALF_CYCLES`, default 12_500_000: clk cycles per blink half-period (2 Hz blink at 50 MHz); minimum 1.
- `LAMP_TEST_CYCLES`, default 50_000_000: clk cycles all segments are lit after reset; minimum 1.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `data_in`  in  32: PIO word; byte k (`[8k+7:8k]`) controls HEXk; synchronous to clk.
- `hex0`, `hex1`, `hex2`, `hex3`  out  7 each: segments, active-low; bit0 = a … bit6 = g.
- `blink_phase`  out  1: 1 = blinking digits visible.
- `lamp_test_active`  out  1: high while in LAMP state.

## Operation
- Byte fields:
  - bit7 `raw`: when 1, bits[6:0] are the segment pattern, 1 = lit, and the output is the bitwise inverse. Blank and blink are ignored.
  - When `raw` = 0: bits[3:0] = nibble; bit4 `blank`; bit5 `blink`; bit6 reserved (ignored).
- Priority when `raw` = 0: blank → 7'h7F. Otherwise, blink with `blink_phase` = 0 → 7'h7F. Otherwise the decoded nibble.
- Decode table, active-low:
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- State machine, 2 states:
  - LAMP (reset state): `hex0`–`hex3` = 7'h00 and `lamp_test_active` = 1. A cycle counter counts 0..`LAMP_TEST_CYCLES`−1; on the terminal count the block goes to RUN.
  - RUN: normal decode. The block stays in RUN until reset.
- Blink timer:
  - Held at 0 with `blink_phase` = 1 during LAMP.
  - In RUN it counts 0..`BLINK_HALF_CYCLES`−1, wraps to 0, and toggles `blink_phase` on each wrap.
- `data_in` is sampled every cycle in both states; a value written during LAMP appears on the first RUN-decoded output.

## Timing
- Reset values:
  - `hex0`–`hex3` = 7'h7F (all off); the outputs show 7'h00 from the first clock after reset release.
  - `blink_phase` = 1.
  - `lamp_test_active` = 1.
  - State = LAMP; both counters = 0.
- Pipeline: `data_in` register → decode → output register. A `data_in` change appears on `hexN` 2 cycles later.
- LAMP duration is exactly `LAMP_TEST_CYCLES` clocks after reset release.
  - `lamp_test_active` falls and the state moves to RUN on the same clock edge, when the counter reaches its terminal count.
  - `hexN` leaves 7'h00 one cycle after RUN entry, carrying the decode of the registered `data_in`.
- `blink_phase` toggles every `BLINK_HALF_CYCLES` cycles in RUN, with the first toggle `BLINK_HALF_CYCLES` cycles after RUN entry. A blinking digit follows the phase with 1 cycle of output-register delay.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously), and the lamp test restarts on release.
- Simultaneous `data_in` change and blink wrap: each takes effect independently with its own latency; no glitch beyond 1 cycle.

## Structure
- Package `hex_display_pkg`:
  - Field bit positions (`RAW_BIT`=7, `BLINK_BIT`=5, `BLANK_BIT`=4).
  - State enum {LAMP, RUN}.
  - Constants `SEG_OFF`=7'h7F and `SEG_ALL`=7'h00.
  - Function `nibble_to_seg`.
- Sub-module `hex_digit_decode`: combinational byte + `blink_phase` → 7-bit active-low segments, instantiated 4×. The state machine, counters, and registers live in the top level.

## Test plan
Test parameters: `LAMP_TEST_CYCLES`=8, `BLINK_HALF_CYCLES`=4.
- Reset release → `hex0`–`hex3` = 7'h00 and `lamp_test_active` = 1 for 8 cycles, then `lamp_test_active` = 0 and decoded digits follow.
- After lamp, `data_in`=32'h00010203 → 2 cycles later `hex0`=30, `hex1`=24, `hex2`=79, `hex3`=40.
- `data_in`=32'h1F0E0D0C → `hex0`=46, `hex1`=21, `hex2`=06, `hex3`=7F (blank wins).
- `data_in`=32'h000000A5 (raw + blink bit set; pattern 7'h25) → `hex0` = 7'h5A constant across `blink_phase` toggles. Then `data_in`=32'h00000025 (blink, nibble 5) → `hex0` alternates 12 / 7F every 4 cycles.
- Sweep nibbles 0–F on `hex3` → matches the decode table exactly.
- Assert `reset_n` mid-blink → outputs 7'h7F and `blink_phase`=1 asynchronously; after release the lamp test repeats for 8 cycles.
